keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_CYCLES, default 50000, clock cycles each row is driven while idle-scanning.
REQ-002 Parameter DEBOUNCE_CYCLES, default 100000, consecutive stable cycles required to accept a press or a release.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cols  input  4  keypad column lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 rows  output  4  keypad row drives, active-low, exactly one bit low at all times.
REQ-007 key_code  output  4  hex code of the last accepted key.
REQ-008 key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-009 s1  output  4  older digit (left display digit), feeds the dual seven-segment display stage.
REQ-010 s2  output  4  newest digit (right display digit).

Function
REQ-011 cols SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value colsync only.
REQ-012 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-013 SCAN: drive row r (rows = ~(1<<r)) for SCAN_CYCLES cycles, then advance r = (r+1) mod 4 (3 wraps to 0).
REQ-014 SCAN -> DEBOUNCE when any colsync bit is low; latch r and the lowest-index low column c; scan counter stops.
REQ-015 DEBOUNCE: keep row r driven; count cycles where colsync[c] is low; on reaching DEBOUNCE_CYCLES -> HELD.
REQ-016 DEBOUNCE: if colsync[c] goes high before count completes, return to SCAN on the same row r with the scan counter cleared; no output change.
REQ-017 On DEBOUNCE -> HELD transition: key_valid=1 for exactly that one cycle; key_code, s2 <= map(r,c); s1 <= previous s2, all in the same cycle.
REQ-018 Map (row,col 0..3): row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E,0,F,D.
REQ-019 HELD: keep row r driven; additional keys pressed SHALL be ignored; when colsync[c] goes high -> RELEASE.
REQ-020 RELEASE: count consecutive cycles with colsync[c] high; any low sample returns to HELD with counter cleared; on reaching DEBOUNCE_CYCLES -> SCAN at row (r+1) mod 4.
REQ-021 A key held indefinitely SHALL produce exactly one key_valid pulse.
REQ-022 Counters SHALL be sized as $clog2 of the larger parameter plus 1; no overflow in any state.
REQ-023 Two keys pressed simultaneously in the same row: lowest column index wins; in different rows: first row scanned wins.

Reset
REQ-024 While reset=0: state SCAN, r=0, rows=4'b1110, key_code=0, key_valid=0, s1=0, s2=0, counters and synchronizer cleared.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL abort immediately with no key_valid pulse; first active clk edge after release resumes SCAN at row 0.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-026 Idle, cols=4'b1111 for 40 cycles -> rows cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid never 1.
REQ-027 Press key "5" (model grounds col1 when row1 low), hold 30 cycles, release -> exactly one key_valid pulse, key_code=5, s2=5, s1=0; pulse no earlier than 2+8 cycles after row1 drive and col low.
REQ-028 Press "3" then "A" sequentially, each with full release -> s1=3, s2=A after second pulse (left digit 3, right digit A on the display stage).
REQ-029 Bounce: key "9" toggles every 3 cycles for 20 cycles then stable 20 cycles -> exactly one pulse, key_code=9; bounce on release likewise gives no extra pulse.
REQ-030 Keys "4" and "6" pressed together -> key_code=4 only; pressing "8" while "4" held -> no pulse.
REQ-031 Assert reset during DEBOUNCE of key "7" -> no pulse; rows=1110, s1=s2=0 immediately.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: column sense, row drive and decoded key outputs.
// master = scanner side, slave = keypad/display side.
interface keypad_scanner_if;
  logic [3:0] cols;       // active-low column lines from the keypad
  logic [3:0] rows;       // active-low row drives, one low at a time
  logic [3:0] key_code;   // hex code of the last accepted key
  logic       key_valid;  // single-cycle pulse on a newly accepted key
  logic [3:0] s1;         // older digit (left display digit)
  logic [3:0] s2;         // newest digit (right display digit)

  modport master (
    input  cols,
    output rows, key_code, key_valid, s1, s2
  );

  modport slave (
    output cols,
    input  rows, key_code, key_valid, s1, s2
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scanning, press/release debounce and a
// two-digit shift register feeding a dual seven-segment display stage.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 50000,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,   // asynchronous, active-low
  keypad_scanner_if.master  kp
);

  localparam int MAX_CYC = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       colsync_q, colsync_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [3:0]       s1_q, s1_d;
  logic [3:0]       s2_q, s2_d;
  logic             key_valid_q, key_valid_d;

  logic             any_low;
  logic             key_low;
  logic [1:0]       low_idx;

  // Keypad legend for (row, col)
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Column sense decode: any key down, lowest low column, and the latched key's column
  always_comb begin
    any_low = ~&colsync_q;
    key_low = ~colsync_q[col_q];
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!colsync_q[i]) low_idx = 2'(i);
    end
  end

  // State register plus all datapath flops; synchronizer idles at "no key" so
  // reset never looks like a press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      sync1_q     <= 4'hF;
      colsync_q   <= 4'hF;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      s1_q        <= 4'h0;
      s2_q        <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      colsync_q   <= colsync_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Next-state logic for the scan/debounce/held/release sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:     if (any_low) state_d = DEBOUNCE;
      DEBOUNCE: begin
        if (!key_low)              state_d = SCAN;
        else if (cnt_q == DEB_LAST) state_d = HELD;
      end
      HELD:     if (!key_low) state_d = RELEASE;
      RELEASE:  begin
        if (key_low)               state_d = HELD;
        else if (cnt_q == DEB_LAST) state_d = SCAN;
      end
      default:  state_d = SCAN;
    endcase
  end

  // Datapath: synchronizer, row/column latch, shared counter and key capture
  always_comb begin
    sync1_d     = kp.cols;
    colsync_d   = sync1_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    key_valid_d = 1'b0;
    case (state_q)
      SCAN: begin
        if (any_low) begin
          // row_q already holds the driven row; freeze it and latch the column
          col_d = low_idx;
          cnt_d = '0;
        end else if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          row_d = row_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!key_low) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d       = '0;
          key_valid_d = 1'b1;
          key_code_d  = key_map(row_q, col_q);
          s2_d        = key_map(row_q, col_q);
          s1_d        = s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        cnt_d = '0;
      end
      RELEASE: begin
        if (key_low) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d = '0;
          row_d = row_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Outputs: one-hot-low row drive and registered key/display values
  always_comb begin
    kp.rows      = ~(4'b0001 << row_q);
    kp.key_code  = key_code_q;
    kp.key_valid = key_valid_q;
    kp.s1        = s1_q;
    kp.s2        = s2_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a switch-matrix keypad model.
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_CYCLES(4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  // Keypad model: pressed[row*4+col] shorts that row to that column
  logic [15:0] pressed;
  logic [3:0]  k_cols;
  always_comb begin
    k_cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.rows[r]) k_cols[c] = 1'b0;
  end
  assign kif.cols = k_cols;

  int total;
  int bad;
  int pulses;
  int cyc;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (kif.key_valid === 1'b1) pulses <= pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (kif.key_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic press_release(input int idx, input int hold, output bit seen);
    pressed[idx] = 1'b1;
    wait_valid(100, seen);
    idle(hold);
    pressed[idx] = 1'b0;
    idle(40);
  endtask

  initial begin
    bit         seen;
    bit         prev;
    bit         cond;
    int         t0;
    int         t1;
    int         p0;
    int         run;
    logic [3:0] exp_rows;

    pressed = 16'h0;
    reset   = 1'b0;
    idle(3);
    check("rst_rows", kif.rows, 4'b1110);
    check("rst_code", kif.key_code, 4'h0);
    check("rst_valid", kif.key_valid, 1'b0);
    check("rst_s1", kif.s1, 4'h0);
    check("rst_s2", kif.s2, 4'h0);
    reset = 1'b1;

    // Idle scanning: each row held 4 cycles, wrapping 3 -> 0
    for (int k = 0; k < 20; k++) begin
      exp_rows = ~(4'b0001 << ((k / 4) % 4));
      check("idle_rows", kif.rows, exp_rows);
      @(negedge clk);
    end
    idle(20);
    check("idle_pulses", pulses, 0);
    $display("idle scan: 40 cycles, pulses=%0d", pulses);

    // Key 5 (row1 col1): one pulse, latency from row1-low & col-low onset
    p0 = pulses; seen = 0; t0 = 0; t1 = 0;
    pressed[5] = 1'b1;
    #1;
    cond = (kif.rows == 4'b1101) && (k_cols[1] == 1'b0);
    if (cond) t0 = cyc;
    prev = cond;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      cond = (kif.rows == 4'b1101) && (k_cols[1] == 1'b0);
      if (cond && !prev) t0 = cyc;
      prev = cond;
      if (kif.key_valid === 1'b1) begin seen = 1'b1; t1 = cyc; end
    end
    check("k5_seen", seen, 1'b1);
    check("k5_latency_ge10", ((t1 - t0) >= 10), 1'b1);
    idle(30);
    check("k5_held_pulses", pulses - p0, 1);
    pressed[5] = 1'b0;
    idle(40);
    check("k5_code", kif.key_code, 4'h5);
    check("k5_s2", kif.s2, 4'h5);
    check("k5_s1", kif.s1, 4'h0);
    check("k5_pulses", pulses - p0, 1);
    $display("key 5: code=%h s1=%h s2=%h latency=%0d", kif.key_code, kif.s1, kif.s2, t1 - t0);

    // Key 3 then key A
    p0 = pulses;
    press_release(2, 10, seen);
    check("k3_seen", seen, 1'b1);
    check("k3_s1", kif.s1, 4'h5);
    check("k3_s2", kif.s2, 4'h3);
    $display("key 3: code=%h s1=%h s2=%h", kif.key_code, kif.s1, kif.s2);
    press_release(3, 10, seen);
    check("kA_seen", seen, 1'b1);
    check("kA_code", kif.key_code, 4'hA);
    check("kA_s1", kif.s1, 4'h3);
    check("kA_s2", kif.s2, 4'hA);
    check("k3A_pulses", pulses - p0, 2);
    $display("key A: code=%h s1=%h s2=%h", kif.key_code, kif.s1, kif.s2);

    // Key 9 (row2 col2) with bounce on press and release
    p0 = pulses;
    for (int i = 0; i < 20; i++) begin
      pressed[10] = (((i / 3) % 2) == 0);
      @(negedge clk);
    end
    pressed[10] = 1'b1;
    wait_valid(60, seen);
    check("k9_seen", seen, 1'b1);
    idle(20);
    for (int i = 0; i < 20; i++) begin
      pressed[10] = (((i / 3) % 2) == 1);
      @(negedge clk);
    end
    pressed[10] = 1'b0;
    idle(40);
    check("k9_pulses", pulses - p0, 1);
    check("k9_code", kif.key_code, 4'h9);
    check("k9_s1", kif.s1, 4'hA);
    check("k9_s2", kif.s2, 4'h9);
    $display("key 9 bounce: code=%h pulses=%0d", kif.key_code, pulses - p0);

    // Keys 4 and 6 together, then 8 while 4 is held
    p0 = pulses;
    pressed[4] = 1'b1;
    pressed[6] = 1'b1;
    wait_valid(60, seen);
    check("k46_seen", seen, 1'b1);
    check("k46_code", kif.key_code, 4'h4);
    pressed[6] = 1'b0;
    pressed[9] = 1'b1;
    idle(30);
    check("k8_ignored", pulses - p0, 1);
    check("k8_code", kif.key_code, 4'h4);
    pressed = 16'h0;
    idle(40);
    check("k46_pulses", pulses - p0, 1);
    check("k46_s1", kif.s1, 4'h9);
    check("k46_s2", kif.s2, 4'h4);
    $display("keys 4+6 then 8: code=%h pulses=%0d", kif.key_code, pulses - p0);

    // Key 7 (row2 col0): reset while debouncing
    p0 = pulses; run = 0; seen = 0;
    pressed[8] = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (kif.rows == 4'b1011 && k_cols[0] == 1'b0) run++;
      else run = 0;
      if (run >= 4) seen = 1'b1;
    end
    check("k7_reached_debounce", seen, 1'b1);
    reset = 1'b0;
    #1;
    check("k7_rst_rows", kif.rows, 4'b1110);
    check("k7_rst_s1", kif.s1, 4'h0);
    check("k7_rst_s2", kif.s2, 4'h0);
    check("k7_rst_code", kif.key_code, 4'h0);
    check("k7_rst_valid", kif.key_valid, 1'b0);
    pressed = 16'h0;
    idle(3);
    reset = 1'b1;
    idle(1);
    check("k7_resume_rows", kif.rows, 4'b1110);
    idle(30);
    check("k7_pulses", pulses - p0, 0);
    $display("key 7 reset abort: pulses=%0d rows=%b", pulses - p0, kif.rows);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
